// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the hazard sequencer and the pipeline datapath:
// hazard inputs from ID/EX and the PC / IF-ID / control-mux steering outputs.
interface pipeline_sequencer_if;
  logic       EX_load_instr;
  logic [3:0] EX_RD;
  logic [3:0] ID_Rn;
  logic [3:0] ID_Rm;
  logic [3:0] ID_Rd;
  logic [2:0] ID_uses;
  logic       branch_taken;
  logic       PC_LE;
  logic       IF_ID_LE;
  logic       CU_MUX_S;
  logic       IF_ID_flush;
  logic [1:0] state;

  modport master (
    output EX_load_instr, EX_RD, ID_Rn, ID_Rm, ID_Rd, ID_uses, branch_taken,
    input  PC_LE, IF_ID_LE, CU_MUX_S, IF_ID_flush, state
  );

  modport slave (
    input  EX_load_instr, EX_RD, ID_Rn, ID_Rm, ID_Rd, ID_uses, branch_taken,
    output PC_LE, IF_ID_LE, CU_MUX_S, IF_ID_flush, state
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Load-use stall / taken-branch flush sequencer with same-cycle (Mealy) outputs.
// Define PIPE_SEQ_PERF_CNT_EN to add saturating stall_count / flush_count outputs.
module pipeline_sequencer (
  input  logic                 Clk,
  input  logic                 Clr,
  pipeline_sequencer_if.slave  bus
`ifdef PIPE_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]          stall_count,
  output logic [15:0]          flush_count
`endif
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state_reg, state_next;
  logic   load_use;
  logic   do_stall, do_flush;
  logic   pc_le, if_id_le, cu_mux_s, if_id_flush;

  always_comb begin
    load_use = bus.EX_load_instr &
               ((bus.ID_uses[2] & (bus.EX_RD == bus.ID_Rn)) |
                (bus.ID_uses[1] & (bus.EX_RD == bus.ID_Rm)) |
                (bus.ID_uses[0] & (bus.EX_RD == bus.ID_Rd)));
  end

  // Default outputs are the FILL/reset outputs; Clr forces them regardless of state.
  always_comb begin
    state_next  = FILL;
    pc_le       = 1'b1;
    if_id_le    = 1'b1;
    cu_mux_s    = 1'b1;
    if_id_flush = 1'b0;
    do_stall    = 1'b0;
    do_flush    = 1'b0;
    if (!Clr) begin
      case (state_reg)
        FILL: state_next = RUN;
        // STALL inserts its single bubble and then evaluates hazards exactly like RUN,
        // so a branch held back by a stall is resolved here.
        RUN, STALL: begin
          cu_mux_s   = 1'b0;
          state_next = RUN;
          if (load_use) begin
            pc_le      = 1'b0;
            if_id_le   = 1'b0;
            cu_mux_s   = 1'b1;
            state_next = STALL;
            do_stall   = 1'b1;
          end else if (bus.branch_taken) begin
            if_id_flush = 1'b1;
            state_next  = FLUSH;
            do_flush    = 1'b1;
          end
        end
        FLUSH:   state_next = RUN;
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  assign bus.PC_LE       = pc_le;
  assign bus.IF_ID_LE    = if_id_le;
  assign bus.CU_MUX_S    = cu_mux_s;
  assign bus.IF_ID_flush = if_id_flush;
  assign bus.state       = state_reg;

`ifdef PIPE_SEQ_PERF_CNT_EN
  logic [15:0] stall_count_reg, flush_count_reg;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      stall_count_reg <= 16'd0;
      flush_count_reg <= 16'd0;
    end else begin
      if (do_stall && stall_count_reg != 16'hFFFF) begin
        stall_count_reg <= stall_count_reg + 16'd1;
      end
      if (do_flush && flush_count_reg != 16'hFFFF) begin
        flush_count_reg <= flush_count_reg + 16'd1;
      end
    end
  end

  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;
`else
  logic unused_events;
  assign unused_events = do_stall ^ do_flush;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: each step drives inputs at negedge,
// checks the same-cycle outputs, then checks the state after the next rising edge.
module tb_pipeline_sequencer;
  logic Clk = 1'b0;
  logic Clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_sequencer_if bus ();

`ifdef PIPE_SEQ_PERF_CNT_EN
  logic [15:0] stall_count, flush_count;
  pipeline_sequencer dut (.Clk(Clk), .Clr(Clr), .bus(bus.slave),
                          .stall_count(stall_count), .flush_count(flush_count));
`else
  pipeline_sequencer dut (.Clk(Clk), .Clr(Clr), .bus(bus.slave));
`endif

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setin(input logic ld, input logic [3:0] rd, input logic [3:0] rn,
                       input logic [3:0] rm, input logic [3:0] rdd,
                       input logic [2:0] uses, input logic bt);
    bus.EX_load_instr = ld;
    bus.EX_RD         = rd;
    bus.ID_Rn         = rn;
    bus.ID_Rm         = rm;
    bus.ID_Rd         = rdd;
    bus.ID_uses       = uses;
    bus.branch_taken  = bt;
  endtask

  // outs = {PC_LE, IF_ID_LE, CU_MUX_S, IF_ID_flush}
  task automatic step(input string tag, input logic [3:0] outs, input logic [1:0] nxt);
    #1;
    chk({tag, "_outs"}, {12'd0, bus.PC_LE, bus.IF_ID_LE, bus.CU_MUX_S, bus.IF_ID_flush},
        {12'd0, outs});
    @(posedge Clk);
    #1;
    chk({tag, "_state"}, {14'd0, bus.state}, {14'd0, nxt});
    $display("step %s: outs=%b state=%0d", tag,
             {bus.PC_LE, bus.IF_ID_LE, bus.CU_MUX_S, bus.IF_ID_flush}, bus.state);
    @(negedge Clk);
  endtask

  task automatic cnt(input string tag, input logic [15:0] s, input logic [15:0] f);
`ifdef PIPE_SEQ_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, stall_count, s);
    chk({tag, "_flush_cnt"}, flush_count, f);
`else
    if (tag.len() < 0) $display("%0h %0h", s, f);
`endif
  endtask

  initial begin
    Clr = 1'b1;
    setin(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b0);
    @(negedge Clk);

    // Reset held two cycles, with a hazard present to prove it is ignored
    setin(1'b1, 4'h3, 4'h3, 4'h0, 4'h0, 3'b100, 1'b1);
    step("rst1", 4'b1110, 2'd0);
    step("rst2", 4'b1110, 2'd0);
    cnt("rst", 16'd0, 16'd0);
    Clr = 1'b0;
    setin(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b0);
    step("fill", 4'b1110, 2'd1);
    step("run_idle", 4'b1100, 2'd1);

    // Load-use on Rn
    setin(1'b1, 4'h3, 4'h3, 4'h0, 4'h0, 3'b100, 1'b0);
    step("lu_rn", 4'b0010, 2'd2);
    setin(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b0);
    step("stall_bubble", 4'b1100, 2'd1);
    cnt("after_stall", 16'd1, 16'd0);

    // Taken branch, FLUSH ignores further branch/load-use
    setin(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b1);
    step("br", 4'b1101, 2'd3);
    setin(1'b1, 4'h7, 4'h7, 4'h0, 4'h0, 3'b100, 1'b1);
    step("flush_slot", 4'b1110, 2'd1);
    cnt("after_flush", 16'd1, 16'd1);

    // Simultaneous load-use and branch: stall wins, branch resolves next cycle
    setin(1'b1, 4'h9, 4'h0, 4'h9, 4'h0, 3'b010, 1'b1);
    step("both", 4'b0010, 2'd2);
    setin(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b1);
    step("br_after_stall", 4'b1101, 2'd3);
    setin(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b0);
    step("flush2", 4'b1110, 2'd1);
    cnt("after_both", 16'd2, 16'd2);

    // Register matches that must not stall
    setin(1'b1, 4'h5, 4'h0, 4'h5, 4'h0, 3'b000, 1'b0);
    step("no_use", 4'b1100, 2'd1);
    setin(1'b0, 4'h5, 4'h5, 4'h5, 4'h5, 3'b111, 1'b0);
    step("not_load", 4'b1100, 2'd1);
    setin(1'b1, 4'h5, 4'h6, 4'h7, 4'h8, 3'b111, 1'b0);
    step("no_match", 4'b1100, 2'd1);

    // Load-use via store data (Rd), then back-to-back load-use while stalled
    setin(1'b1, 4'hA, 4'h0, 4'h0, 4'hA, 3'b001, 1'b0);
    step("lu_rd", 4'b0010, 2'd2);
    setin(1'b1, 4'hB, 4'h0, 4'hB, 4'h0, 3'b010, 1'b0);
    step("lu_b2b", 4'b0010, 2'd2);
    cnt("b2b", 16'd4, 16'd2);

    // Reset mid-STALL
    Clr = 1'b1;
    step("clr_in_stall", 4'b1110, 2'd0);
    cnt("clr", 16'd0, 16'd0);
    Clr = 1'b0;
    setin(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b0);
    step("refill", 4'b1110, 2'd1);

    // Reset mid-FLUSH
    setin(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b1);
    step("br3", 4'b1101, 2'd3);
    Clr = 1'b1;
    step("clr_in_flush", 4'b1110, 2'd0);
    Clr = 1'b0;
    setin(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b0);
    step("refill2", 4'b1110, 2'd1);
    step("run_end", 4'b1100, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have ports: Clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: Clr  in  1  synchronous active-high reset, sampled on rising Clk.
REQ-003 SHALL have: EX_load_instr  in  1  instruction in EX is a load.
REQ-004 SHALL have: EX_RD  in  4  destination register of the EX instruction.
REQ-005 SHALL have: ID_Rn, ID_Rm, ID_Rd  in  4 each  source fields I19_16, I3_0, I15_12 of the ID instruction.
REQ-006 SHALL have: ID_uses  in  3  bit2=Rn read, bit1=Rm read, bit0=Rd read (store data).
REQ-007 SHALL have: branch_taken  in  1  ID branch resolved taken this cycle.
REQ-008 SHALL have: PC_LE  out  1  PC register load enable.
REQ-009 SHALL have: IF_ID_LE  out  1  IF/ID pipeline register load enable.
REQ-010 SHALL have: CU_MUX_S  out  1  1 = CU mux forces all-zero (NOP) control into ID/EX.
REQ-011 SHALL have: IF_ID_flush  out  1  1 = IF/ID loads zero (bubble) on next edge.
REQ-012 SHALL have: state  out  2  current FSM state, FILL=0, RUN=1, STALL=2, FLUSH=3.

Function
REQ-013 SHALL implement Moore state register plus Mealy outputs: outputs depend on state and same-cycle inputs.
REQ-014 load_use SHALL = EX_load_instr & ((ID_uses[2] & EX_RD==ID_Rn) | (ID_uses[1] & EX_RD==ID_Rm) | (ID_uses[0] & EX_RD==ID_Rd)).
REQ-015 FILL: PC_LE=1, IF_ID_LE=1, CU_MUX_S=1, IF_ID_flush=0; inputs ignored; unconditional transition to RUN after one cycle.
REQ-016 RUN, no event: PC_LE=1, IF_ID_LE=1, CU_MUX_S=0, IF_ID_flush=0; stay RUN.
REQ-017 RUN, load_use=1: PC_LE=0, IF_ID_LE=0, CU_MUX_S=1, IF_ID_flush=0; next state STALL.
REQ-018 RUN, branch_taken=1 and load_use=0: PC_LE=1, IF_ID_LE=1, CU_MUX_S=0, IF_ID_flush=1; next state FLUSH.
REQ-019 load_use and branch_taken simultaneous SHALL give stall priority; branch re-evaluated in the following cycle.
REQ-020 STALL: exactly one bubble; outputs as RUN-no-event (PC and IF/ID advance, CU_MUX_S=0); next state RUN; back-to-back load-use in STALL SHALL re-enter STALL (outputs per REQ-017).
REQ-021 FLUSH: CU_MUX_S=1 (squashed slot), PC_LE=1, IF_ID_LE=1, IF_ID_flush=0; branch_taken and load_use ignored; next state RUN.
REQ-022 Stall/flush latency SHALL be zero cycles (same-cycle outputs); penalty: load-use 1 cycle, taken branch 1 cycle.
REQ-023 Illegal state encodings SHALL not occur; any unreachable encoding SHALL go to FILL.

Reset
REQ-024 Clr=1 at a rising edge SHALL set state=FILL regardless of current state, including mid-STALL or mid-FLUSH.
REQ-025 While Clr=1 outputs SHALL equal FILL outputs (PC_LE=1, IF_ID_LE=1, CU_MUX_S=1, IF_ID_flush=0).
REQ-026 Performance counters (if compiled in) SHALL reset to 0 on Clr.

Configuration
REQ-027 Macro PIPE_SEQ_PERF_CNT_EN SHALL, when defined, add outputs stall_count  out  16 and flush_count  out  16.
REQ-028 stall_count SHALL increment on each edge where REQ-017 applies; flush_count on each edge where REQ-018 applies; both saturate at 16'hFFFF.
REQ-029 Without the macro the ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 Clr=1 two cycles, then release -> state 0 one cycle (CU_MUX_S=1), then state 1, outputs 1,1,0,0.
REQ-031 RUN, EX_load_instr=1, EX_RD=4'h3, ID_Rn=4'h3, ID_uses=3'b100 -> same cycle PC_LE=0, IF_ID_LE=0, CU_MUX_S=1; next state 2; then RUN; stall_count=1.
REQ-032 RUN, branch_taken=1, load_use=0 -> IF_ID_flush=1 that cycle; next cycle state 3, CU_MUX_S=1; then RUN; flush_count=1.
REQ-033 RUN, load_use=1 and branch_taken=1 together -> STALL taken, IF_ID_flush=0; next cycle branch_taken=1 -> FLUSH path.
REQ-034 EX_RD=ID_Rm=4'h5 but ID_uses=3'b000 -> no stall; EX_RD match with EX_load_instr=0 -> no stall.
REQ-035 Clr=1 while state=2 -> next state 0; counters 0 (with PIPE_SEQ_PERF_CNT_EN).
